// File: rtl/clock_pkg.sv
// Shared constants and types for the digital clock: digit indices, BCD digit
// limits and the packed HH:MM:SS payload.
package clock_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned TIME_W     = DIGIT_W * NUM_DIGITS;

    // Digit indices as produced by the select FSM (6 and 7 are unused codes)
    localparam logic [SEL_W-1:0] DIG_H10 = 3'd0;
    localparam logic [SEL_W-1:0] DIG_H1  = 3'd1;
    localparam logic [SEL_W-1:0] DIG_M10 = 3'd2;
    localparam logic [SEL_W-1:0] DIG_M1  = 3'd3;
    localparam logic [SEL_W-1:0] DIG_S10 = 3'd4;
    localparam logic [SEL_W-1:0] DIG_S1  = 3'd5;

    // Largest legal value of each digit class
    localparam logic [DIGIT_W-1:0] LIM_UNITS = 4'd9;
    localparam logic [DIGIT_W-1:0] LIM_TENS  = 4'd5;
    localparam logic [DIGIT_W-1:0] LIM_H10   = 4'd2;
    localparam logic [DIGIT_W-1:0] LIM_H1_HI = 4'd3;

    // Six BCD digits, most significant (h10) first
    typedef struct packed {
        logic [DIGIT_W-1:0] h10;
        logic [DIGIT_W-1:0] h1;
        logic [DIGIT_W-1:0] m10;
        logic [DIGIT_W-1:0] m1;
        logic [DIGIT_W-1:0] s10;
        logic [DIGIT_W-1:0] s1;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;
    localparam bcd_time_t DAY_END   = '{h10: 4'd2, h1: 4'd3, m10: 4'd5,
                                        m1: 4'd9, s10: 4'd5, s1: 4'd9};

    // Increment one BCD digit, wrapping to 0 once it has reached lim
    function automatic logic [DIGIT_W-1:0] bcd_wrap_inc(
        input logic [DIGIT_W-1:0] d,
        input logic [DIGIT_W-1:0] lim
    );
        return (d >= lim) ? '0 : d + DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Control/display bundle between the select FSM, time_keeper and the display mux.
interface time_keeper_if;

    logic                               set;
    logic [clock_pkg::SEL_W-1:0]        sel;
    logic                               up;
    logic [clock_pkg::TIME_W-1:0]       digits;
    logic                               sec_tick;
    logic                               day_wrap;

    modport master (
        output set, sel, up,
        input  digits, sec_tick, day_wrap
    );

    modport slave (
        input  set, sel, up,
        output digits, sec_tick, day_wrap
    );

endinterface

// File: rtl/time_keeper_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1, held at 0 while hold is high,
// and flags the terminal count for exactly one cycle.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    output logic tc_c
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Prescaler count; hold restarts it so the next second is a full period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (hold || (cnt == TERM)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Terminal count is suppressed while held, so set wins over a coincident tick
    assign tc_c = !hold && (cnt == TERM);

endmodule

// File: rtl/time_keeper.sv
// Running HH:MM:SS time as six BCD digits: one-second advance with carry in run
// mode, per-digit wrapping edits in set mode.
module time_keeper
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic          clk,
    input  logic          reset,
    time_keeper_if.slave  bus
);

    bcd_time_t          cur;
    bcd_time_t          nxt_c;
    bcd_time_t          adv_c;
    bcd_time_t          edt_c;
    logic               tick_c;
    logic [DIGIT_W-1:0] h1_lim_c;
    logic               cy_s10_c;
    logic               cy_m1_c;
    logic               cy_m10_c;
    logic               cy_h1_c;
    logic               cy_h10_c;
    logic               sec_tick_q;
    logic               day_wrap_q;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .hold  (bus.set),
        .tc_c  (tick_c)
    );

    // h1 tops out at 3 in the twenties, otherwise at 9
    assign h1_lim_c = (cur.h10 >= LIM_H10) ? LIM_H1_HI : LIM_UNITS;

    // One-second advance: ripple carry through the six digits
    always_comb begin
        adv_c    = cur;
        cy_s10_c = (cur.s1 >= LIM_UNITS);
        cy_m1_c  = cy_s10_c && (cur.s10 >= LIM_TENS);
        cy_m10_c = cy_m1_c  && (cur.m1  >= LIM_UNITS);
        cy_h1_c  = cy_m10_c && (cur.m10 >= LIM_TENS);
        cy_h10_c = cy_h1_c  && (cur.h1  >= h1_lim_c);

        adv_c.s1 = bcd_wrap_inc(cur.s1, LIM_UNITS);
        if (cy_s10_c) adv_c.s10 = bcd_wrap_inc(cur.s10, LIM_TENS);
        if (cy_m1_c)  adv_c.m1  = bcd_wrap_inc(cur.m1,  LIM_UNITS);
        if (cy_m10_c) adv_c.m10 = bcd_wrap_inc(cur.m10, LIM_TENS);
        if (cy_h1_c)  adv_c.h1  = bcd_wrap_inc(cur.h1,  h1_lim_c);
        if (cy_h10_c) adv_c.h10 = bcd_wrap_inc(cur.h10, LIM_H10);
    end

    // Single-digit edit, no carry; entering the twenties clamps h1 to 3
    always_comb begin
        edt_c = cur;
        case (bus.sel)
            DIG_H10: begin
                edt_c.h10 = bcd_wrap_inc(cur.h10, LIM_H10);
                if ((edt_c.h10 == LIM_H10) && (cur.h1 > LIM_H1_HI)) begin
                    edt_c.h1 = LIM_H1_HI;
                end
            end
            DIG_H1:  edt_c.h1  = bcd_wrap_inc(cur.h1,  h1_lim_c);
            DIG_M10: edt_c.m10 = bcd_wrap_inc(cur.m10, LIM_TENS);
            DIG_M1:  edt_c.m1  = bcd_wrap_inc(cur.m1,  LIM_UNITS);
            DIG_S10: edt_c.s10 = bcd_wrap_inc(cur.s10, LIM_TENS);
            DIG_S1:  edt_c.s1  = bcd_wrap_inc(cur.s1,  LIM_UNITS);
            default: edt_c = cur;
        endcase
    end

    // Mode select: edits only in set mode, seconds only in run mode
    always_comb begin
        nxt_c = cur;
        if (bus.set) begin
            if (bus.up) nxt_c = edt_c;
        end else if (tick_c) begin
            nxt_c = adv_c;
        end
    end

    // Time register and one-cycle event pulses aligned with the new value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= TIME_ZERO;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            cur        <= nxt_c;
            sec_tick_q <= tick_c;
            day_wrap_q <= tick_c && (cur == DAY_END);
        end
    end

    assign bus.digits   = cur;
    assign bus.sec_tick = sec_tick_q;
    assign bus.day_wrap = day_wrap_q;

endmodule

// File: tb/tb_time_keeper.sv
// Randomised and directed bench for time_keeper against a seconds-of-day model.
module tb_time_keeper;

    localparam int TD = 10;

    logic clk = 1'b0;
    logic reset;

    time_keeper_if tk_if ();

    time_keeper #(
        .TICK_DIV (TD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tk_if.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // reference state: time as seconds since midnight plus cycles since last tick
    int secs;
    int pre;
    bit etk;
    bit ewr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] pack_time(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int model_digit(input int idx);
        logic [23:0] p;
        p = pack_time(secs);
        return int'(p[(5 - idx) * 4 +: 4]);
    endfunction

    // edit one decimal position of the model time, by the clock's digit rules
    task automatic model_edit(input int idx);
        int d[6];
        int mx;
        for (int i = 0; i < 6; i++) d[i] = model_digit(i);
        case (idx)
            0: mx = 2;
            1: mx = (d[0] == 2) ? 3 : 9;
            2, 4: mx = 5;
            default: mx = 9;
        endcase
        d[idx] = (d[idx] >= mx) ? 0 : d[idx] + 1;
        if (idx == 0 && d[0] == 2 && d[1] > 3) d[1] = 3;
        secs = (d[0] * 10 + d[1]) * 3600 + (d[2] * 10 + d[3]) * 60 + d[4] * 10 + d[5];
    endtask

    task automatic model_reset();
        secs = 0;
        pre  = 0;
        etk  = 1'b0;
        ewr  = 1'b0;
    endtask

    // one clock: model consumes the same inputs, outputs compared #1 later
    task automatic step();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (tk_if.set) begin
            pre = 0;
            etk = 1'b0;
            ewr = 1'b0;
            if (tk_if.up && tk_if.sel < 3'd6) model_edit(int'(tk_if.sel));
        end else begin
            etk = 1'b0;
            ewr = 1'b0;
            if (pre == TD - 1) begin
                pre  = 0;
                secs = (secs + 1) % 86400;
                etk  = 1'b1;
                ewr  = (secs == 0);
            end else begin
                pre++;
            end
        end
        #1;
        chk("digits",   32'(tk_if.digits),   32'(pack_time(secs)));
        chk("sec_tick", 32'(tk_if.sec_tick), 32'(etk));
        chk("day_wrap", 32'(tk_if.day_wrap), 32'(ewr));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_up(input int idx);
        tk_if.sel = 3'(idx);
        tk_if.up  = 1'b1;
        step();
        tk_if.up  = 1'b0;
    endtask

    // drive one digit to a target value through edit pulses (set must be high)
    task automatic set_digit(input int idx, input int val);
        for (int k = 0; k < 16 && model_digit(idx) != val; k++) pulse_up(idx);
        chk("preload", 32'(model_digit(idx)), 32'(val));
    endtask

    // count cycles until the next sec_tick, bounded
    task automatic wait_tick(input string tag, input int exp_gap);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tk_if.sec_tick && n < 4 * TD);
        chk(tag, 32'(n), 32'(exp_gap));
    endtask

    int s10_seq[7] = '{1, 2, 3, 4, 5, 0, 1};
    int wraps;

    initial begin
        reset     = 1'b1;
        tk_if.set = 1'b0;
        tk_if.sel = 3'd0;
        tk_if.up  = 1'b0;
        model_reset();
        #1;
        chk("reset_digits", 32'(tk_if.digits), 32'h0);
        chk("reset_tick",   32'(tk_if.sec_tick), 32'h0);
        chk("reset_wrap",   32'(tk_if.day_wrap), 32'h0);
        run(3);
        reset = 1'b0;

        // first second and the first minute
        run(10);
        chk("first_sec", 32'(tk_if.digits), 32'h000001);
        run(590);
        chk("first_min", 32'(tk_if.digits), 32'h000100);

        // s10 edit sequence, frozen time while editing
        tk_if.set = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            pulse_up(4);
            chk("s10_seq", 32'(tk_if.digits[7:4]), 32'(s10_seq[i]));
        end
        chk("s10_others", 32'(tk_if.digits & 24'hFFFF0F), 32'h000100);

        // hour clamp: 19 -> 23, then h1 wraps to 0 -> 20
        set_digit(0, 1);
        set_digit(1, 9);
        pulse_up(0);
        chk("h_clamp", 32'(tk_if.digits[23:16]), 32'h23);
        pulse_up(1);
        chk("h1_wrap", 32'(tk_if.digits[23:16]), 32'h20);
        pulse_up(0);
        chk("h10_wrap", 32'(tk_if.digits[23:16]), 32'h00);

        // day rollover from 23:59:58
        set_digit(0, 2); set_digit(1, 3); set_digit(2, 5);
        set_digit(3, 9); set_digit(4, 5); set_digit(5, 8);
        chk("pre_2359", 32'(tk_if.digits), 32'h235958);
        tk_if.set = 1'b0;
        wraps = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tk_if.day_wrap) begin
                wraps++;
                chk("wrap_with_tick", 32'(tk_if.sec_tick), 32'h1);
            end
            if (i == 9) chk("at_235959", 32'(tk_if.digits), 32'h235959);
        end
        chk("after_wrap", 32'(tk_if.digits), 32'h000000);
        chk("wrap_count", 32'(wraps), 32'd1);

        // frozen for 35 cycles, then a full period before the next second
        run(4);
        tk_if.set = 1'b1;
        run(35);
        chk("frozen", 32'(tk_if.digits), 32'h000000);
        tk_if.set = 1'b0;
        wait_tick("tick_after_set", TD);

        // invalid select leaves time alone
        tk_if.set = 1'b1;
        pulse_up(6);
        pulse_up(7);
        chk("sel_invalid", 32'(tk_if.digits), 32'h000001);

        // asynchronous reset mid-count at 12:34:56
        set_digit(0, 1); set_digit(1, 2); set_digit(2, 3);
        set_digit(3, 4); set_digit(4, 5); set_digit(5, 6);
        tk_if.set = 1'b0;
        run(4);
        chk("pre_reset", 32'(tk_if.digits), 32'h123456);
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_reset", 32'(tk_if.digits), 32'h000000);
        run(2);
        reset = 1'b0;
        wait_tick("tick_after_reset", TD);
        chk("one_after_reset", 32'(tk_if.digits), 32'h000001);

        // random mix of set levels, selects and up pulses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) tk_if.set = ~tk_if.set;
            tk_if.sel = 3'($urandom_range(0, 7));
            tk_if.up  = ($urandom_range(0, 2) == 0);
            step();
        end
        tk_if.up = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
